// File: rtl/univ_reg_cell.sv
// Multi-mode register cell: hold, load, shift, rotate, count.
// Serial chaining outputs, terminal-count strobe and sticky overflow.
module univ_reg_cell #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             r,
   input  logic             clr,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] notq,
   output logic             sout_l,
   output logic             sout_r,
   output logic             tc,
   output logic             ovf
);

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_LOAD = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_SHR  = 3'b011;
   localparam logic [2:0] M_ROL  = 3'b100;
   localparam logic [2:0] M_ROR  = 3'b101;
   localparam logic [2:0] M_UP   = 3'b110;
   localparam logic [2:0] M_DOWN = 3'b111;

   logic [WIDTH-1:0] q_nxt;
   logic             at_max;
   logic             at_min;

   assign notq   = ~q;
   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];
   assign at_max = &q;
   assign at_min = ~|q;

   // High in the cycle before a wrap edge, usable as a cascade enable
   assign tc = en & ~clr &
      (((mode == M_UP) & at_max) | ((mode == M_DOWN) & at_min));

   always_comb begin
      q_nxt = q;
      unique case (mode)
         M_HOLD: q_nxt = q;
         M_LOAD: q_nxt = d;
         M_SHL:  q_nxt = {q[WIDTH-2:0], sin_r};
         M_SHR:  q_nxt = {sin_l, q[WIDTH-1:1]};
         M_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
         M_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
         M_UP:   q_nxt = q + 1'b1;
         M_DOWN: q_nxt = q - 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         q   <= RESET_VALUE;
         ovf <= 1'b0;
      end else if (clr) begin
         q   <= '0;
         ovf <= 1'b0;
      end else if (en) begin
         q <= q_nxt;
         if (tc) ovf <= 1'b1;
      end
   end

endmodule
